// File: rtl/flow_dequant.sv
// flow_dequant: 3-stage dequantizer (table read, multiply, reduce) with block-position tracking.
// Define FLOW_DEQUANT_SAT_EN to saturate results to 16 bits; otherwise the low 16 bits are kept.
module flow_dequant #(
  parameter int N  = 2,
  parameter int QW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cfg_we,
  input  logic [5:0]      cfg_addr,
  input  logic [QW-1:0]   cfg_data,
  input  logic            in_valid,
  input  logic [N*16-1:0] in_data,
  input  logic            in_sob,
  input  logic            in_eob,
  input  logic            in_sof,
  output logic            out_valid,
  output logic [N*16-1:0] out_data,
  output logic            out_sob,
  output logic            out_eob,
  output logic            out_sof,
  output logic            out_err
);

  localparam int BEATS = 64 / N;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 16 + QW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [QW-1:0] qtab_reg [64];
  logic [BW-1:0] b_reg;
  logic [BW-1:0] b_used;
  logic          accept;
  logic          frame_bad;
  logic          err_reg;

  logic s1_valid_reg, s1_sob_reg, s1_eob_reg, s1_sof_reg;
  logic s2_valid_reg, s2_sob_reg, s2_eob_reg, s2_sof_reg;
  logic out_valid_reg, out_sob_reg, out_eob_reg, out_sof_reg;

  assign accept = in_valid & en;
  assign b_used = in_sob ? '0 : b_reg;

  // sob/eob on one beat is always caught here because LAST_BEAT is never 0 for legal N
  assign frame_bad = (in_eob && (b_used != LAST_BEAT)) ||
                     (!in_eob && (b_used == LAST_BEAT)) ||
                     (in_sof && !in_sob);

  // Table writes ignore en; stage-1 reads below see the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) qtab_reg[k] <= QW'(1);
    end else if (cfg_we) begin
      qtab_reg[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg   <= '0;
      err_reg <= 1'b0;
    end else if (accept) begin
      b_reg <= b_used + BW'(1);
      if (frame_bad) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sob_reg    <= 1'b0;
      s1_eob_reg    <= 1'b0;
      s1_sof_reg    <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_sob_reg    <= 1'b0;
      s2_eob_reg    <= 1'b0;
      s2_sof_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sob_reg   <= 1'b0;
      out_eob_reg   <= 1'b0;
      out_sof_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg  <= in_valid;
      s1_sob_reg    <= in_valid & in_sob;
      s1_eob_reg    <= in_valid & in_eob;
      s1_sof_reg    <= in_valid & in_sof;
      s2_valid_reg  <= s1_valid_reg;
      s2_sob_reg    <= s1_sob_reg;
      s2_eob_reg    <= s1_eob_reg;
      s2_sof_reg    <= s1_sof_reg;
      out_valid_reg <= s2_valid_reg;
      out_sob_reg   <= s2_sob_reg;
      out_eob_reg   <= s2_eob_reg;
      out_sof_reg   <= s2_sof_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [5:0]             lane_idx;
      logic signed [15:0]     coef_reg;
      logic [QW-1:0]          q_reg;
      logic signed [PW-1:0]   prod_reg;
      logic signed [15:0]     res;
      logic signed [15:0]     dout_reg;

      assign lane_idx = 6'(int'(b_used) * N + gi);

`ifdef FLOW_DEQUANT_SAT_EN
      localparam logic signed [PW-1:0] SAT_MAX = PW'(32767);
      localparam logic signed [PW-1:0] SAT_MIN = PW'(-32768);
      always_comb begin
        res = prod_reg[15:0];
        if (prod_reg > SAT_MAX)      res = 16'sh7fff;
        else if (prod_reg < SAT_MIN) res = 16'sh8000;
      end
`else
      always_comb begin
        res = prod_reg[15:0];
      end
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          coef_reg <= '0;
          q_reg    <= '0;
          prod_reg <= '0;
          dout_reg <= '0;
        end else if (en) begin
          coef_reg <= in_data[gi*16 +: 16];
          q_reg    <= qtab_reg[lane_idx];
          // zero-extend the unsigned table entry so the multiply stays signed
          prod_reg <= coef_reg * $signed({1'b0, q_reg});
          dout_reg <= res;
        end
      end

      assign out_data[gi*16 +: 16] = dout_reg;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_sob   = out_sob_reg;
  assign out_eob   = out_eob_reg;
  assign out_sof   = out_sof_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_flow_dequant.sv
// Directed self-checking bench for flow_dequant (N=2, QW=8): identity, table load, stall,
// write collision, saturation/wrap, framing error and reset.
module tb_flow_dequant;
  localparam int N  = 2;
  localparam int QW = 8;
`ifdef FLOW_DEQUANT_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = -7144;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            cfg_we;
  logic [5:0]      cfg_addr;
  logic [QW-1:0]   cfg_data;
  logic            in_valid;
  logic [N*16-1:0] in_data;
  logic            in_sob, in_eob, in_sof;
  logic            out_valid;
  logic [N*16-1:0] out_data;
  logic            out_sob, out_eob, out_sof;
  logic            out_err;

  flow_dequant #(.N(N), .QW(QW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
    .out_valid(out_valid), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int sb;
    int e_acc;
    int w_acc;
    int w_lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   wall_exp_next = -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // An output beat is consumed at the first edge where it is present with en=1.
  always @(negedge clk) begin
    if (!rst && en && out_valid) begin
      if (q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        cur = q.pop_front();
        check("lane0", int'($signed(out_data[15:0])), cur.d0);
        check("lane1", int'($signed(out_data[31:16])), cur.d1);
        check("sideband", int'({out_sob, out_eob, out_sof}), cur.sb);
        check("en_latency", en_cnt + 1 - cur.e_acc, 3);
        if (cur.w_lat >= 0) check("wall_latency", cyc + 1 - cur.w_acc, cur.w_lat);
        $display("out beat lane0=%0d lane1=%0d sob=%0b eob=%0b sof=%0b",
                 $signed(out_data[15:0]), $signed(out_data[31:16]), out_sob, out_eob, out_sof);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c0, input int c1, input int e0, input int e1,
                      input logic sob, input logic eob, input logic sof);
    exp_t x;
    in_valid = 1'b1;
    in_data  = {c1[15:0], c0[15:0]};
    in_sob   = sob;
    in_eob   = eob;
    in_sof   = sof;
    tick();
    x.d0 = e0;
    x.d1 = e1;
    x.sb = int'({sob, eob, sof});
    x.e_acc = en_cnt;
    x.w_acc = cyc;
    x.w_lat = wall_exp_next;
    q.push_back(x);
    wall_exp_next = -1;
    in_valid = 1'b0;
    in_sob   = 1'b0;
    in_eob   = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = addr[5:0];
    cfg_data = data[QW-1:0];
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    idle(3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_sideband", int'({out_sob, out_eob, out_sof}), 0);
    rst = 1'b0;

    // identity after reset: 0..63 passes through
    for (int b = 0; b < 32; b++)
      send(2*b, 2*b+1, 2*b, 2*b+1, b == 0, b == 31, b == 0);
    idle(5);
    check("err_identity", int'(out_err), 0);

    // table load Q[k]=k+1, block of -3 with a 5-cycle stall after beat 10
    for (int k = 0; k < 64; k++) cfg_write(k, k + 1);
    for (int b = 0; b < 32; b++) begin
      if (b == 10) wall_exp_next = 8;
      send(-3, -3, -3*(2*b+1), -3*(2*b+2), b == 0, b == 31, 1'b0);
      if (b == 10) begin
        in_valid = 1'b1;
        in_data  = {16'hfffd, 16'hfffd};
        en = 1'b0;
        idle(5);
        check("stall_valid", int'(out_valid), 1);
        check("stall_lane0", int'($signed(out_data[15:0])), -51);
        check("stall_lane1", int'($signed(out_data[31:16])), -54);
        en = 1'b1;
      end
    end
    idle(5);
    check("err_table", int'(out_err), 0);

    // write collision: stage 1 reads the old Q[0]
    cfg_write(0, 4);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 8'd9;
    send(2, 0, 8, 0, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;
    send(2, 0, 18, 0, 1'b1, 1'b0, 1'b0);
    idle(5);

    // large product: saturate or wrap
    cfg_write(0, 255);
    send(1000, 0, SAT_EXP, 0, 1'b1, 1'b0, 1'b0);
    idle(5);
    check("err_before_frame", int'(out_err), 0);

    // framing: eob on beat 20
    for (int b = 0; b < 21; b++) begin
      send(1, 1, (b == 0) ? 255 : 2*b+1, 2*b+2, b == 0, b == 20, b == 0);
      if (b == 19) check("err_beat19", int'(out_err), 0);
      if (b == 20) check("err_set", int'(out_err), 1);
    end
    for (int b = 0; b < 32; b++)
      send(0, 0, 0, 0, b == 0, b == 31, b == 0);
    idle(5);
    check("err_sticky", int'(out_err), 1);

    // reset mid-block discards in-flight beats and restores identity table
    send(5, 5, 0, 0, 1'b1, 1'b0, 1'b0);
    send(5, 5, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);
    q.delete();
    check("rst2_err", int'(out_err), 0);
    check("rst2_valid", int'(out_valid), 0);
    check("rst2_data", int'(out_data), 0);
    rst = 1'b0;
    idle(5);
    send(7, -7, 7, -7, 1'b1, 1'b0, 1'b0);
    idle(5);
    check("err_after_rst", int'(out_err), 0);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/flow_dequant.md
# flow_dequant

Pipelined dequantizer for the JPEG flow datapath. It is the decode-side counterpart of the quantizing multiplier. It accepts N quantized DCT coefficients per beat, with the flow sideband (valid/sob/eob/sof). It tracks each coefficient's position inside the 64-coefficient block and multiplies it by the matching entry of an internally stored, run-time-loadable quantization table. It emits 16-bit reconstructed coefficients with the sideband aligned, ahead of the IDCT.

## Interface
Parameters:
- N, 2: lanes per beat; legal values 1, 2, 4, 8 (must divide 64)
- QW, 8: quantization table entry width, unsigned

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global advance; 0 freezes every pipeline register, counter and output
- cfg_we  in  1  table write strobe
- cfg_addr  in  6  table index 0..63, natural (non-zigzag) order
- cfg_data  in  QW  table value
- in_valid  in  1  input beat valid
- in_data  in  N×16  signed quantized coefficients; lane i is index b*N+i
- in_sob / in_eob / in_sof  in  1 each  start of block, end of block, start of frame (qualify in_valid)
- out_valid  out  1  output beat valid
- out_data  out  N×16  signed dequantized coefficients
- out_sob / out_eob / out_sof  out  1 each  sideband delayed with the data
- out_err  out  1  sticky block-framing error

## Operation
- Beat acceptance: a beat is accepted when in_valid=1 and en=1. If en=0, the input is ignored and upstream must hold it.
- Beat counter b:
  - Width log2(64/N), reset 0.
  - On an accepted beat with in_sob=1, that beat uses b=0.
  - Otherwise the beat uses the current b.
  - After each accepted beat, b becomes (used b)+1, wrapping to 0 after 64/N−1.
- Table:
  - 64×QW registers; every entry resets to 1, so the block is identity after reset.
  - A write with cfg_we=1 updates the entry at the clock edge and is independent of en.
  - Stage 1 samples the table before the write, so a beat reading the same address in the same cycle gets the old value.
- Stage 1: register the coefficients, the N table values at b*N+i, and the sideband.
- Stage 2:
  - Full signed product, 16 × (QW+1) bits, with the table value zero-extended to signed; width 16+QW+1 (25 at default).
  - Registered.
- Stage 3: reduce the product to 16 bits (see Configuration) and drive the outputs.
- Framing check: out_err sets and stays 1 until rst when an accepted beat has either:
  - in_eob=1 with used b≠64/N−1, or
  - used b=64/N−1 with in_eob=0.
- A sof beat must also be a sob beat; sof without sob sets out_err.
- Data still passes unmodified through all framing errors.

## Timing
- Latency: 3 advancing (en=1) cycles from the accepted beat to out_valid.
- Stages advance only when en=1. When en=0, the outputs hold their values and out_valid holds its level, with no duplicate beat counted downstream. Downstream qualifies the output with en.
- Bubbles (in_valid=0, en=1) propagate as out_valid=0 and do not move b.
- out_err asserts 1 en-cycle after the offending beat is accepted.
- Reset state:
  - out_valid, out_sob, out_eob, out_sof and out_err are 0; out_data is 0.
  - b is 0; all pipeline registers are cleared; all table entries are 1.
  - A reset mid-block discards all in-flight beats.
  - The next block must start with sob. Without sob, counting starts at 0 and the check runs as normal.
- Simultaneous sob and eob on one beat is legal only for N=64, which is not a legal value. For every legal N it sets out_err.

## Configuration
- FLOW_DEQUANT_SAT_EN defined: stage 3 saturates the product to the range [−32768, 32767].
- Not defined: stage 3 takes the product's low 16 bits (two's-complement wrap). This saves the compare logic.

## Test plan
- Identity after reset (N=2):
  - Stimulus: one 32-beat block with sob on beat 0, eob on beat 31, coefficient values 0..63.
  - Response: out_data equals the input, 3 cycles later, sideband aligned, out_err=0.
- Table load:
  - Stimulus: write Q[k]=k+1, then send a block with every coefficient −3.
  - Response: lane i of beat b gives −3·(b·2+i+1); index 63 gives −192.
- Saturation:
  - Stimulus: Q[0]=255 and in_data lane0=1000 on a sob beat.
  - Response with FLOW_DEQUANT_SAT_EN defined: 32767.
  - Response without it: −7144 (low 16 bits of 255000).
- Stall:
  - Stimulus: drop en for 5 cycles in mid-block while in_valid=1.
  - Response: outputs frozen, b unchanged, no beats lost or duplicated, total latency = 3 + 5.
- Framing:
  - Stimulus: eob on beat 20.
  - Response: out_err=1 one cycle later and it stays 1; a following clean block does not clear it; rst clears it.
- Write collision:
  - Stimulus: cfg_we to address 0 with value 9, in the same cycle as a sob beat with coefficient 2 while Q[0]=4.
  - Response: the output is 8; the next block's index 0 gives 18.
